seq_restoring_divider: RTL and testbench

- Iterative unsigned integer divider. Computes quotient and remainder of dividend_i / divisor_i, one quotient bit per clock (radix-2 restoring).
- Inverse arithmetic companion to the team's Booth multiplier. Serves the posit datapath where mantissa division or reciprocal is needed and area matters more than latency.
- Valid/ready handshake on input and output. Holds one operation at a time.

---
 rtl/seq_restoring_divider.sv | 150 +++++++++++++++
 tb/tb_seq_restoring_divider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per clock,
// valid/ready handshake on both sides, one operation in flight at a time.
module seq_restoring_divider #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH_N-1:0] dividend_i,
    input  logic [WIDTH_D-1:0] divisor_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH_N-1:0] quotient_o,
    output logic [WIDTH_D-1:0] remainder_o,
    output logic               div_by_zero_o
);

    localparam int CNT_W = $clog2(WIDTH_N + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH_N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH_D-1:0] divisor_r;
    logic [WIDTH_N-1:0] shift_r;
    logic [WIDTH_D-1:0] prem_r;
    logic [CNT_W-1:0]   count_r;
    logic               dz_r;
    logic [WIDTH_D:0]   step_s;

    // One restoring step. The trial value needs WIDTH_D+1 bits so a divisor of
    // 2^WIDTH_D-1 still compares correctly; the kept remainder is always below
    // the divisor, so its top bit is known zero and is not stored.
    function automatic logic [WIDTH_D:0] restore_step(
        input logic [WIDTH_D-1:0] prem,
        input logic               next_bit,
        input logic [WIDTH_D-1:0] dv
    );
        logic [WIDTH_D:0] trial;
        logic [WIDTH_D:0] diff;
        trial = {prem, next_bit};
        diff  = trial - {1'b0, dv};
        if (trial >= {1'b0, dv}) begin
            restore_step = {1'b1, diff[WIDTH_D-1:0]};
        end else begin
            restore_step = {1'b0, trial[WIDTH_D-1:0]};
        end
    endfunction

    assign step_s = restore_step(prem_r, shift_r[WIDTH_N-1], divisor_r);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid_i) begin
                    if (divisor_i != {WIDTH_D{1'b0}}) begin
                        state_s = BUSY;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (count_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture and iterative quotient/remainder datapath.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            divisor_r <= {WIDTH_D{1'b0}};
            shift_r   <= {WIDTH_N{1'b0}};
            prem_r    <= {WIDTH_D{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            dz_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid_i) begin
                        divisor_r <= divisor_i;
                        count_r   <= CNT_LOAD;
                        if (divisor_i != {WIDTH_D{1'b0}}) begin
                            shift_r <= dividend_i;
                            prem_r  <= {WIDTH_D{1'b0}};
                            dz_r    <= 1'b0;
                        end else begin
                            // Zero divisor: saturated quotient, dividend passes through as remainder.
                            shift_r <= {WIDTH_N{1'b1}};
                            prem_r  <= dividend_i[WIDTH_D-1:0];
                            dz_r    <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    prem_r  <= step_s[WIDTH_D-1:0];
                    shift_r <= {shift_r[WIDTH_N-2:0], step_s[WIDTH_D]};
                    count_r <= count_r - CNT_ONE;
                end
                DONE: begin
                    prem_r <= prem_r;
                end
                default: begin
                    prem_r <= prem_r;
                end
            endcase
        end
    end

    assign in_ready_o    = (state_r == IDLE);
    assign out_valid_o   = (state_r == DONE);
    assign quotient_o    = shift_r;
    assign remainder_o   = prem_r;
    assign div_by_zero_o = dz_r;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomised checks of seq_restoring_divider at 16/16 and 8/4 widths.
module tb_seq_restoring_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [15:0] a_dividend = 16'd0;
    logic [15:0] a_divisor = 16'd0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [15:0] a_q;
    logic [15:0] a_r;
    logic        a_dz;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_dividend = 8'd0;
    logic [3:0]  b_divisor = 4'd0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [7:0]  b_q;
    logic [3:0]  b_r;
    logic        b_dz;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH_N(16), .WIDTH_D(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .dividend_i(a_dividend), .divisor_i(a_divisor),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .quotient_o(a_q), .remainder_o(a_r), .div_by_zero_o(a_dz)
    );

    seq_restoring_divider #(.WIDTH_N(8), .WIDTH_D(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .dividend_i(b_dividend), .divisor_i(b_divisor),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .quotient_o(b_q), .remainder_o(b_r), .div_by_zero_o(b_dz)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation on the 16-bit instance; hold>0 applies backpressure for that many cycles.
    task automatic do_op_a(input logic [15:0] nd, input logic [15:0] dv,
                           input logic [15:0] eq, input logic [15:0] er,
                           input logic edz, input int hold, input string tag);
        int lat;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 32'(a_in_ready), 32'd1);
        a_out_ready = (hold == 0);
        a_in_valid  = 1'b1;
        a_dividend  = nd;
        a_divisor   = dv;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_dividend = ~nd;
        a_divisor  = ~dv;
        lat = 0;
        while (!a_out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), edz ? 32'd0 : 32'd16);
        check_eq({tag, "_q"}, 32'(a_q), 32'(eq));
        check_eq({tag, "_r"}, 32'(a_r), 32'(er));
        check_eq({tag, "_dz"}, 32'(a_dz), 32'(edz));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, 32'(a_out_valid), 32'd1);
            check_eq({tag, "_hold_q"}, 32'(a_q), 32'(eq));
            check_eq({tag, "_hold_r"}, 32'(a_r), 32'(er));
            check_eq({tag, "_hold_in_ready"}, 32'(a_in_ready), 32'd0);
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_valid_drop"}, 32'(a_out_valid), 32'd0);
        check_eq({tag, "_idle"}, 32'(a_in_ready), 32'd1);
    endtask

    // Issue one operation on the 8/4 instance, checked against integer division.
    task automatic do_op_b(input logic [7:0] nd, input logic [3:0] dv);
        int lat;
        logic [7:0] eq;
        logic [3:0] er;
        if (dv == 4'd0) begin
            eq = 8'hFF;
            er = nd[3:0];
        end else begin
            eq = 8'(nd / dv);
            er = 4'(nd % dv);
        end
        @(negedge clk);
        b_in_valid = 1'b1;
        b_dividend = nd;
        b_divisor  = dv;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_dividend = 8'($urandom);
        b_divisor  = 4'($urandom);
        lat = 0;
        while (!b_out_valid && lat < 32) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("b_lat", 32'(lat), (dv == 4'd0) ? 32'd0 : 32'd8);
        check_eq("b_q", 32'(b_q), 32'(eq));
        check_eq("b_r", 32'(b_r), 32'(er));
        check_eq("b_dz", 32'(b_dz), 32'(dv == 4'd0));
        if (dv != 4'd0) begin
            check_eq("b_invariant", 32'(b_q) * 32'(dv) + 32'(b_r), 32'(nd));
            check_eq("b_rem_lt_div", 32'(b_r < dv), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen_valid;
        logic [7:0] nd;
        logic [3:0] dv;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(a_out_valid), 32'd0);
        check_eq("rst_q", 32'(a_q), 32'd0);
        check_eq("rst_r", 32'(a_r), 32'd0);
        check_eq("rst_dz", 32'(a_dz), 32'd0);
        check_eq("rst_in_ready", 32'(a_in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        do_op_a(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 0, "d100_7");
        do_op_a(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 0, "dmax_max");
        do_op_a(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 0, "dmax_1");
        do_op_a(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 0, "d5_9");
        do_op_a(16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b1, 0, "dzero");
        do_op_a(16'd8, 16'd2, 16'd4, 16'd0, 1'b0, 0, "d8_2");
        do_op_a(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 10, "bp1000_33");

        // Abort an operation partway through BUSY with an asynchronous reset.
        @(negedge clk);
        a_in_valid = 1'b1;
        a_dividend = 16'd1000;
        a_divisor  = 16'd33;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", 32'(a_out_valid), 32'd0);
        check_eq("abort_q", 32'(a_q), 32'd0);
        check_eq("abort_r", 32'(a_r), 32'd0);
        check_eq("abort_dz", 32'(a_dz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) check_eq("abort_in_ready", 32'(a_in_ready), 32'd1);
            if (a_out_valid) seen_valid++;
        end
        check_eq("abort_no_result", 32'(seen_valid), 32'd0);
        do_op_a(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 0, "d9_3");

        // Boundary values on the narrow instance, then random operands.
        do_op_b(8'd255, 4'd15);
        do_op_b(8'd255, 4'd1);
        do_op_b(8'd14, 4'd15);
        do_op_b(8'hA7, 4'd0);
        for (int k = 0; k < 2000; k++) begin
            nd = 8'($urandom_range(0, 255));
            dv = ($urandom_range(0, 99) < 5) ? 4'd0 : 4'($urandom_range(1, 15));
            do_op_b(nd, dv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
